// File: rtl/reg_file_param.sv
// reg_file_param
//   Parametrised register bank: 2^ADDR_W entries of DATA_W bits.
//   It has one synchronous write port and two combinational read ports.
//   The one-hot write-select vector is exported for debug and trace.
//
// Parameters
//   DATA_W   : width of each entry
//   ADDR_W   : address width, DEPTH = 2^ADDR_W
//   ZERO_REG : 1 = entry 0 is hardwired to zero and writes to it are dropped
//   BYPASS   : 1 = a read of the address being written this cycle returns wr_data
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   reset_n    : synchronous active-low reset, clears every entry
//   we         : write enable
//   wr_addr    : write address
//   wr_data    : write data
//   rd_addr_a  : read address, port A
//   rd_data_a  : read data, port A (combinational)
//   rd_addr_b  : read address, port B
//   rd_data_b  : read data, port B (combinational)
//   we_onehot  : decoded write select (combinational, zero during reset)
module reg_file_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [ADDR_W-1:0]        rd_addr_a,
  output logic [DATA_W-1:0]        rd_data_a,
  input  logic [ADDR_W-1:0]        rd_addr_b,
  output logic [DATA_W-1:0]        rd_data_b,
  output logic [(1<<ADDR_W)-1:0]   we_onehot
);

  localparam int DEPTH = 1 << ADDR_W;

  // Current contents of every entry, as seen by the read muxes.
  logic [DATA_W-1:0] stored [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    if (ZERO_REG != 0 && gi == 0) begin : g_zero
      // Entry 0 has no storage: it never decodes and always reads zero.
      assign we_onehot[gi] = 1'b0;
      assign stored[gi]    = '0;
    end else begin : g_reg
      logic [DATA_W-1:0] entry_q;
      logic [DATA_W-1:0] entry_d;

      // Gating the decode with reset_n makes reset dominate a same-cycle write,
      // and it keeps the exported select vector quiet during reset.
      assign we_onehot[gi] = we & reset_n & (wr_addr == ADDR_W'(gi));

      always_comb begin
        entry_d = entry_q;
        if (we_onehot[gi]) begin
          entry_d = wr_data;
        end
      end

      always_ff @(posedge clk) begin
        if (!reset_n) begin
          entry_q <= '0;
        end else begin
          entry_q <= entry_d;
        end
      end

      assign stored[gi] = entry_q;
    end
  end

  // Read priority: the hardwired zero first, then the bypass of the
  // in-flight write, then storage.
  always_comb begin
    rd_data_a = stored[rd_addr_a];
    if (BYPASS != 0 && we_onehot[rd_addr_a]) begin
      rd_data_a = wr_data;
    end
    if (ZERO_REG != 0 && rd_addr_a == '0) begin
      rd_data_a = '0;
    end
  end

  always_comb begin
    rd_data_b = stored[rd_addr_b];
    if (BYPASS != 0 && we_onehot[rd_addr_b]) begin
      rd_data_b = wr_data;
    end
    if (ZERO_REG != 0 && rd_addr_b == '0) begin
      rd_data_b = '0;
    end
  end

endmodule

// File: tb/tb_reg_file_param.sv
// Testbench for reg_file_param. It drives three configurations from one
// stimulus stream:
//   u_a : DATA_W=32, ADDR_W=3, ZERO_REG=0, BYPASS=1 (defaults)
//   u_b : DATA_W=32, ADDR_W=3, ZERO_REG=1, BYPASS=0
//   u_c : DATA_W=8,  ADDR_W=4, ZERO_REG=0, BYPASS=1
// The expected responses come from an array model and go into a queue.
// A monitor process pops each entry on the falling edge and compares it.
module tb_reg_file_param;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [2:0]  rd_addr_a = '0;
  logic [2:0]  rd_addr_b = '0;
  logic [3:0]  wr_addr_c = '0;
  logic [3:0]  rd_addr_a_c = '0;
  logic [3:0]  rd_addr_b_c = '0;

  logic [31:0] rd_data_a_a, rd_data_b_a, rd_data_a_b, rd_data_b_b;
  logic [7:0]  rd_data_a_c, rd_data_b_c;
  logic [7:0]  oh_a, oh_b;
  logic [15:0] oh_c;

  always #5 clk = ~clk;

  reg_file_param #(.DATA_W(32), .ADDR_W(3), .ZERO_REG(0), .BYPASS(1)) u_a (
    .clk(clk), .reset_n(reset_n), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a_a),
    .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b_a), .we_onehot(oh_a));

  reg_file_param #(.DATA_W(32), .ADDR_W(3), .ZERO_REG(1), .BYPASS(0)) u_b (
    .clk(clk), .reset_n(reset_n), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a_b),
    .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b_b), .we_onehot(oh_b));

  reg_file_param #(.DATA_W(8), .ADDR_W(4), .ZERO_REG(0), .BYPASS(1)) u_c (
    .clk(clk), .reset_n(reset_n), .we(we), .wr_addr(wr_addr_c), .wr_data(wr_data[7:0]),
    .rd_addr_a(rd_addr_a_c), .rd_data_a(rd_data_a_c),
    .rd_addr_b(rd_addr_b_c), .rd_data_b(rd_data_b_c), .we_onehot(oh_c));

  typedef struct {
    int          idx;
    bit          chk_rd;
    logic [7:0]  oh_a, oh_b;
    logic [15:0] oh_c;
    logic [31:0] ra_a, rb_a, ra_b, rb_b;
    logic [7:0]  ra_c, rb_c;
  } exp_t;

  exp_t exp_q[$];

  // Reference contents, updated with the spec's write/reset rules.
  logic [31:0] mem_a [8];
  logic [31:0] mem_b [8];
  logic [7:0]  mem_c [16];
  bit          model_valid = 1'b0;

  int errors = 0;
  int checks = 0;
  int txn = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  // One cycle of stimulus: drive inputs, push the expected response, advance the model.
  task automatic step(input bit rst_n_i, input bit we_i, input logic [2:0] wa,
                      input logic [31:0] wd, input logic [2:0] ra, input logic [2:0] rb,
                      input logic [3:0] wac, input logic [3:0] rac, input logic [3:0] rbc);
    exp_t e;
    bit   wen;
    @(posedge clk);
    #1;
    reset_n = rst_n_i; we = we_i; wr_addr = wa; wr_data = wd;
    rd_addr_a = ra; rd_addr_b = rb;
    wr_addr_c = wac; rd_addr_a_c = rac; rd_addr_b_c = rbc;

    wen = we_i && rst_n_i;
    e.idx = txn;
    txn++;
    e.chk_rd = model_valid;
    e.oh_a = '0; e.oh_b = '0; e.oh_c = '0;
    if (wen) begin
      e.oh_a[wa] = 1'b1;
      if (wa != 3'd0) e.oh_b[wa] = 1'b1;
      e.oh_c[wac] = 1'b1;
    end
    // Config A: the in-flight write is visible immediately.
    e.ra_a = (wen && wa == ra) ? wd : mem_a[ra];
    e.rb_a = (wen && wa == rb) ? wd : mem_a[rb];
    // Config B: entry 0 reads zero, and a write becomes visible only after the edge.
    e.ra_b = (ra == 3'd0) ? 32'h0 : mem_b[ra];
    e.rb_b = (rb == 3'd0) ? 32'h0 : mem_b[rb];
    // Config C: narrow, deep, with bypass.
    e.ra_c = (wen && wac == rac) ? wd[7:0] : mem_c[rac];
    e.rb_c = (wen && wac == rbc) ? wd[7:0] : mem_c[rbc];
    exp_q.push_back(e);

    if (!rst_n_i) begin
      for (int i = 0; i < 8; i++) begin mem_a[i] = '0; mem_b[i] = '0; end
      for (int i = 0; i < 16; i++) mem_c[i] = '0;
      model_valid = 1'b1;
    end else if (we_i) begin
      mem_a[wa] = wd;
      if (wa != 3'd0) mem_b[wa] = wd;
      mem_c[wac] = wd[7:0];
    end
  endtask

  // Monitor: the combinational outputs are sampled at mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        $display("txn %0d: rst_n=%0b we=%0b wa=%0d wd=%h ra=%0d rb=%0d | A %h/%h B %h/%h C %h/%h oh %h %h %h",
                 e.idx, reset_n, we, wr_addr, wr_data, rd_addr_a, rd_addr_b,
                 rd_data_a_a, rd_data_b_a, rd_data_a_b, rd_data_b_b,
                 rd_data_a_c, rd_data_b_c, oh_a, oh_b, oh_c);
        check("onehot_a", {24'h0, oh_a}, {24'h0, e.oh_a});
        check("onehot_b", {24'h0, oh_b}, {24'h0, e.oh_b});
        check("onehot_c", {16'h0, oh_c}, {16'h0, e.oh_c});
        if (e.chk_rd) begin
          check("rd_a_cfgA", rd_data_a_a, e.ra_a);
          check("rd_b_cfgA", rd_data_b_a, e.rb_a);
          check("rd_a_cfgB", rd_data_a_b, e.ra_b);
          check("rd_b_cfgB", rd_data_b_b, e.rb_b);
          check("rd_a_cfgC", {24'h0, rd_data_a_c}, {24'h0, e.ra_c});
          check("rd_b_cfgC", {24'h0, rd_data_b_c}, {24'h0, e.rb_c});
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 8; i++) begin mem_a[i] = '0; mem_b[i] = '0; end
    for (int i = 0; i < 16; i++) mem_c[i] = '0;

    // Reset for two cycles, then sweep every address on both ports.
    step(1'b0, 1'b0, 3'd0, 32'h0, 3'd0, 3'd0, 4'd0, 4'd0, 4'd0);
    step(1'b0, 1'b0, 3'd0, 32'h0, 3'd0, 3'd0, 4'd0, 4'd0, 4'd0);
    for (int i = 0; i < 16; i++)
      step(1'b1, 1'b0, 3'd0, 32'h0, 3'(i), 3'(7 - i), 4'd0, 4'(i), 4'(15 - i));

    // Decoder walk, then read back every entry.
    for (int i = 0; i < 8; i++)
      step(1'b1, 1'b1, 3'(i), 32'h11111111 * (i + 1), 3'(i), 3'(i + 7), 4'(i), 4'(i), 4'(i + 1));
    for (int i = 0; i < 8; i++)
      step(1'b1, 1'b0, 3'd0, 32'h0, 3'(i), 3'(7 - i), 4'd0, 4'(i), 4'(7 - i));

    // Bypass versus registered visibility on entry 5.
    step(1'b1, 1'b1, 3'd5, 32'hAAAA5555, 3'd0, 3'd1, 4'd5, 4'd0, 4'd1);
    step(1'b1, 1'b1, 3'd5, 32'hDEADBEEF, 3'd5, 3'd5, 4'd5, 4'd5, 4'd5);
    step(1'b1, 1'b0, 3'd0, 32'h0, 3'd5, 3'd5, 4'd0, 4'd5, 4'd5);

    // Write to address 0: discarded by the zero-register configuration.
    step(1'b1, 1'b1, 3'd0, 32'h12345678, 3'd0, 3'd0, 4'd0, 4'd0, 4'd0);
    step(1'b1, 1'b0, 3'd0, 32'h0, 3'd0, 3'd0, 4'd0, 4'd0, 4'd0);

    // Reset takes priority over a same-cycle write.
    step(1'b0, 1'b1, 3'd3, 32'hCAFEF00D, 3'd3, 3'd3, 4'd3, 4'd3, 4'd3);
    step(1'b1, 1'b0, 3'd0, 32'h0, 3'd3, 3'd5, 4'd0, 4'd3, 4'd5);

    // Deep configuration: write the top entry; every other entry stays zero.
    step(1'b1, 1'b1, 3'd1, 32'h000000A5, 3'd2, 3'd1, 4'd15, 4'd15, 4'd14);
    for (int i = 0; i < 16; i++)
      step(1'b1, 1'b0, 3'd0, 32'h0, 3'(i), 3'd1, 4'd0, 4'(i), 4'd15);

    // Random traffic with occasional resets and forced read/write collisions.
    for (int n = 0; n < 300; n++) begin
      logic [2:0]  wa, ra, rb;
      logic [3:0]  wac, rac, rbc;
      logic [31:0] wd;
      bit          rst_n_r, we_r;
      rst_n_r = ($urandom_range(0, 39) != 0);
      we_r    = ($urandom_range(0, 3) != 0);
      wa  = 3'($urandom_range(0, 7));
      wac = 4'($urandom_range(0, 15));
      wd  = $urandom;
      ra  = ($urandom_range(0, 3) == 0) ? wa : 3'($urandom_range(0, 7));
      rb  = ($urandom_range(0, 3) == 0) ? wa : 3'($urandom_range(0, 7));
      rac = ($urandom_range(0, 3) == 0) ? wac : 4'($urandom_range(0, 15));
      rbc = ($urandom_range(0, 3) == 0) ? wac : 4'($urandom_range(0, 15));
      step(rst_n_r, we_r, wa, wd, ra, rb, wac, rac, rbc);
    end

    // Let the monitor drain the queue within a bounded number of cycles.
    for (int w = 0; w < 4 && exp_q.size() != 0; w++) @(posedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_file_param.md
# reg_file_param

Parametrised register file: DEPTH = 2^ADDR_W entries of DATA_W bits each, with one synchronous write port and two combinational read ports. The write address goes through a one-hot decoder that scales to ADDR_W bits and is exposed as an output. The block adds three options: synchronous reset of the array, an optional hardwired-zero entry 0, and optional same-cycle write-to-read bypass. It sits in the datapath as the general-purpose register bank; the decode vector feeds the debug/trace logic.

## Interface
- DATA_W, 32, width of each entry
- ADDR_W, 3, address width; DEPTH = 2^ADDR_W (default 8)
- ZERO_REG, 0, 1 = entry 0 always reads 0 and its writes are discarded
- BYPASS, 1, 1 = a read of the address being written this cycle returns wr_data
- clk  input  1  clock; all state updates on rising edge
- reset_n  input  1  synchronous, active-low reset
- we  input  1  write enable
- wr_addr  input  ADDR_W  write address
- wr_data  input  DATA_W  write data
- rd_addr_a  input  ADDR_W  read address, port A
- rd_data_a  output  DATA_W  read data, port A (combinational)
- rd_addr_b  input  ADDR_W  read address, port B
- rd_data_b  output  DATA_W  read data, port B (combinational)
- we_onehot  output  DEPTH  decoded write select (combinational)

## Operation
- Decoder: we_onehot[i] = 1 iff we=1, reset_n=1 and wr_addr=i. Otherwise all zeros.
  - At most one bit is ever set.
  - Full decode: every wr_addr value maps to exactly one bit, so there is no default/X case.
- With ZERO_REG=1, we_onehot[0] is always 0.
- Write: at a rising clk with reset_n=1, every entry i with we_onehot[i]=1 loads wr_data. All other entries hold.
- Reset: at a rising clk with reset_n=0, all entries clear to 0.
  - Reset dominates we; a write in the same cycle is dropped.
  - Reset mid-sequence discards all prior contents.
- Read, per port independently:
  - ZERO_REG=1 and rd_addr=0 → output 0.
  - Otherwise, BYPASS=1 and we_onehot[rd_addr]=1 → output wr_data.
  - Otherwise → output the stored entry.
- Both ports may read the same address, or the write address, in the same cycle; there is no conflict.
- Arithmetic: none. Data passes through unmodified at full DATA_W. Addresses are unsigned.

## Timing
- Reset values:
  - All entries read 0 after the first rising clk with reset_n=0.
  - we_onehot = 0 while reset_n=0.
  - rd_data_a/b = 0 after reset, until written.
- Write latency:
  - BYPASS=0: the new value is visible on reads in the cycle after the rising edge.
  - BYPASS=1: the value is visible combinationally in the same cycle we is asserted, and from storage thereafter.
- Read latency: 0 cycles, combinational from rd_addr and storage.
- we_onehot: 0-cycle combinational from we/wr_addr/reset_n.
- Back-to-back writes to the same address every cycle: the last write wins at each edge, with no stall.
- Power-up before the first reset: contents undefined. The bench must apply reset_n=0 for at least 1 rising edge.

## Test plan
- Reset then full sweep: reset_n=0 for 2 cycles, then read all 8 addresses on both ports → all 0x00000000; we_onehot=0x00.
- Decode: we=1, wr_addr 0..7 with data 0x11111111*(addr+1) → we_onehot walks 0x01,0x02,…,0x80. Then read back all 8 addresses → each holds its written value; with we=0, we_onehot=0x00.
- Bypass: BYPASS=1, entry 5 holds 0xAAAA5555. Write 0xDEADBEEF to 5 while rd_addr_a=5 → rd_data_a=0xDEADBEEF in that same cycle. With BYPASS=0, the same stimulus gives 0xAAAA5555 in that cycle and 0xDEADBEEF in the next.
- Zero register: ZERO_REG=1, write 0x12345678 to address 0 → we_onehot=0x00, rd_data_a=0 during and after the write. ZERO_REG=0 → reads 0x12345678 on the next cycle.
- Reset dominates: we=1, wr_addr=3, wr_data=0xCAFEF00D with reset_n=0 at the same edge → entry 3 reads 0 afterwards and we_onehot=0x00 during that cycle.
- Parametrisation: ADDR_W=4, DATA_W=8. Write 0xA5 to address 15 → we_onehot=0x8000; rd_addr_b=15 next cycle → 0xA5; other addresses remain 0.
